// File: rtl/bin_phase_sequencer.sv
// bin_phase_sequencer
//   Bank of per-bin phase counters producing {bin, phase} addresses for the
//   sin/cos lookup tables of a DFT octave stage. Each bin has a programmable
//   last-valid phase (max) and a start phase that a bank-wide sync reloads.
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset
//   cfg_we     config write strobe (updates max_tab/start_tab of cfg_bin)
//   cfg_bin    config target bin (out-of-range bins are ignored)
//   cfg_max    period-1, the last valid phase of cfg_bin
//   cfg_start  phase loaded into cfg_bin's counter on sync
//   sync       reload every counter with its start phase
//   req_valid  advance request
//   req_ready  request accepted when req_valid & req_ready (low during sync)
//   req_bin    bin to read and advance
//   req_step   phase advance amount
//   out_valid  address valid, one cycle after accept
//   out_addr   {bin, pre-advance phase}
//   out_wrap   the advance wrapped the period
//   out_err    illegal step, stale counter, or out-of-range bin
module bin_phase_sequencer #(
    parameter int N      = 6,
    parameter int BINS   = 24,
    parameter int STEP_W = 2,
    localparam int BW    = $clog2(BINS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [BW-1:0]     cfg_bin,
    input  logic [N-1:0]      cfg_max,
    input  logic [N-1:0]      cfg_start,
    input  logic              sync,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BW-1:0]     req_bin,
    input  logic [STEP_W-1:0] req_step,
    output logic              out_valid,
    output logic [BW+N-1:0]   out_addr,
    output logic              out_wrap,
    output logic              out_err
);

    localparam logic [BW:0] BINS_L = BINS[BW:0];

    logic [N-1:0] cnt       [BINS];
    logic [N-1:0] max_tab   [BINS];
    logic [N-1:0] start_tab [BINS];

    // Returns {err, wrap, next_phase}. A step larger than the period is
    // rejected without touching the counter; a counter left beyond a newly
    // shrunk max is forced back to phase 0 and flagged.
    function automatic logic [N+1:0] advance(input logic [N-1:0]      c,
                                             input logic [N-1:0]      m,
                                             input logic [STEP_W-1:0] s);
        logic [N:0]   s_w;
        logic [N:0]   m_w;
        logic [N:0]   t;
        logic [N:0]   t_wrap;
        logic [N+1:0] res;
        s_w    = (N+1)'(s);
        m_w    = {1'b0, m};
        t      = {1'b0, c} + s_w;
        t_wrap = t - m_w - {{N{1'b0}}, 1'b1};
        if (s_w > m_w) begin
            res = {1'b1, 1'b0, c};
        end else if (c > m) begin
            res = {1'b1, 1'b1, {N{1'b0}}};
        end else if (t > m_w) begin
            res = {1'b0, 1'b1, t_wrap[N-1:0]};
        end else begin
            res = {1'b0, 1'b0, t[N-1:0]};
        end
        return res;
    endfunction

    // ---- stage p0: handshake, table read, advance computation
    logic              accept_p0;
    logic              bin_ok_p0;
    logic              cfg_ok_p0;
    logic [BW-1:0]     idx_p0;
    logic [N-1:0]      c_p0;
    logic [N-1:0]      m_p0;
    logic [N+1:0]      adv_p0;

    assign req_ready = rst & ~sync;
    assign accept_p0 = req_valid & req_ready;
    assign bin_ok_p0 = ({1'b0, req_bin} < BINS_L);
    assign cfg_ok_p0 = ({1'b0, cfg_bin} < BINS_L);

    always_comb begin
        idx_p0 = '0;
        if (bin_ok_p0) begin
            idx_p0 = req_bin;
        end
        c_p0   = cnt[idx_p0];
        m_p0   = max_tab[idx_p0];
        adv_p0 = advance(c_p0, m_p0, req_step);
    end

    // Counters: sync has priority; a request can never coincide with sync
    // because req_ready is low then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BINS; i++) begin
                cnt[i] <= '0;
            end
        end else if (sync) begin
            for (int i = 0; i < BINS; i++) begin
                cnt[i] <= start_tab[i];
            end
        end else if (accept_p0 && bin_ok_p0) begin
            cnt[idx_p0] <= adv_p0[N-1:0];
        end
    end

    // Config tables: written at the edge, so a same-cycle request or sync
    // still sees the previous contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BINS; i++) begin
                max_tab[i]   <= '1;
                start_tab[i] <= '0;
            end
        end else if (cfg_we && cfg_ok_p0) begin
            max_tab[cfg_bin]   <= cfg_max;
            start_tab[cfg_bin] <= cfg_start;
        end
    end

    // ---- stage p1: registered table address
    logic              vld_p1;
    logic [BW+N-1:0]   addr_p1;
    logic              wrap_p1;
    logic              err_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            wrap_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                if (bin_ok_p0) begin
                    addr_p1 <= {req_bin, c_p0};
                    wrap_p1 <= adv_p0[N];
                    err_p1  <= adv_p0[N+1];
                end else begin
                    addr_p1 <= {req_bin, {N{1'b0}}};
                    wrap_p1 <= 1'b0;
                    err_p1  <= 1'b1;
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_addr  = addr_p1;
    assign out_wrap  = wrap_p1;
    assign out_err   = err_p1;

endmodule

// File: tb/tb_bin_phase_sequencer.sv
// Testbench for bin_phase_sequencer: directed scenarios plus randomized
// traffic, with expectations from a period-modulo reference model pushed to
// a queue and popped by an independent output monitor.
module tb_bin_phase_sequencer;

    localparam int N      = 6;
    localparam int BINS   = 24;
    localparam int STEP_W = 2;
    localparam int BW     = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [BW-1:0]     cfg_bin;
    logic [N-1:0]      cfg_max;
    logic [N-1:0]      cfg_start;
    logic              sync;
    logic              req_valid;
    logic              req_ready;
    logic [BW-1:0]     req_bin;
    logic [STEP_W-1:0] req_step;
    logic              out_valid;
    logic [BW+N-1:0]   out_addr;
    logic              out_wrap;
    logic              out_err;

    always #5 clk = ~clk;

    bin_phase_sequencer #(.N(N), .BINS(BINS), .STEP_W(STEP_W)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .cfg_we    (cfg_we),
        .cfg_bin   (cfg_bin),
        .cfg_max   (cfg_max),
        .cfg_start (cfg_start),
        .sync      (sync),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bin   (req_bin),
        .req_step  (req_step),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_wrap  (out_wrap),
        .out_err   (out_err)
    );

    typedef struct packed {
        logic [BW+N-1:0] addr;
        logic            wrap;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    int cnt_m   [BINS];
    int max_m   [BINS];
    int start_m [BINS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BINS; i++) begin
            cnt_m[i]   = 0;
            max_m[i]   = (1 << N) - 1;
            start_m[i] = 0;
        end
    endtask

    // One clock cycle of stimulus; the model is advanced in the order the
    // hardware must honour: request uses old max, sync uses old start.
    task automatic drive(input bit we, input int cb, input int cm, input int cs,
                         input bit sy, input bit rv, input int rb, input int rs);
        exp_t e;
        int   c;
        int   m;
        cfg_we    = we;
        cfg_bin   = BW'(cb);
        cfg_max   = N'(cm);
        cfg_start = N'(cs);
        sync      = sy;
        req_valid = rv;
        req_bin   = BW'(rb);
        req_step  = STEP_W'(rs);
        #1;
        check("req_ready", {31'd0, req_ready}, {31'd0, !sy});
        if (rv && !sy) begin
            if (rb >= BINS) begin
                e.addr = (BW+N)'(rb * (1 << N));
                e.wrap = 1'b0;
                e.err  = 1'b1;
            end else begin
                c      = cnt_m[rb];
                m      = max_m[rb];
                e.addr = (BW+N)'(rb * (1 << N) + c);
                if (rs > m) begin
                    e.wrap = 1'b0;
                    e.err  = 1'b1;
                end else if (c > m) begin
                    cnt_m[rb] = 0;
                    e.wrap    = 1'b1;
                    e.err     = 1'b1;
                end else begin
                    cnt_m[rb] = (c + rs) % (m + 1);
                    e.wrap    = (c + rs) > m;
                    e.err     = 1'b0;
                end
            end
            exp_q.push_back(e);
        end
        if (sy) begin
            for (int i = 0; i < BINS; i++) cnt_m[i] = start_m[i];
        end
        if (we && cb < BINS) begin
            max_m[cb]   = cm;
            start_m[cb] = cs;
        end
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        sync      = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic req(input int rb, input int rs);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, rb, rs);
    endtask

    task automatic cfg(input int cb, input int cm, input int cs);
        drive(1'b1, cb, cm, cs, 1'b0, 1'b0, 0, 0);
    endtask

    // Output monitor: every valid output must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_addr", {21'd0, out_addr}, {21'd0, mon_e.addr});
                check("out_wrap", {31'd0, out_wrap}, {31'd0, mon_e.wrap});
                check("out_err",  {31'd0, out_err},  {31'd0, mon_e.err});
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_bin   = '0;
        cfg_max   = '0;
        cfg_start = '0;
        sync      = 1'b0;
        req_valid = 1'b0;
        req_bin   = '0;
        req_step  = '0;
        model_reset();

        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_addr",  {21'd0, out_addr},  32'd0);
        check("rst_out_wrap",  {31'd0, out_wrap},  32'd0);
        check("rst_out_err",   {31'd0, out_err},   32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bin 3, period 51: phases 0..50 then 0..8
        cfg(3, 50, 0);
        for (int i = 0; i < 60; i++) req(3, 1);

        // Bin 0, period 55, step 2 across the wrap from 53
        cfg(0, 54, 0);
        for (int i = 0; i < 26; i++) req(0, 2);
        req(0, 1);
        req(0, 2);
        req(0, 2);

        // Start phases then sync with a request present
        cfg(5, 63, 23);
        cfg(23, 63, 15);
        drive(1'b0, 0, 0, 0, 1'b1, 1'b1, 5, 1);
        check("sync_no_valid", {31'd0, out_valid}, 32'd0);
        req(5, 1);
        req(23, 1);

        // Stale counter after max shrinks
        for (int i = 0; i < 40; i++) req(7, 1);
        cfg(7, 29, 0);
        req(7, 1);
        req(7, 1);

        // Same-cycle cfg and request on bin 2 uses the old max
        for (int i = 0; i < 8; i++) req(2, 1);
        drive(1'b1, 2, 9, 0, 1'b0, 1'b1, 2, 3);
        req(2, 1);

        // Illegal step, out-of-range bin, period-1 bin
        cfg(9, 2, 0);
        req(9, 3);
        req(9, 1);
        req(24, 1);
        req(31, 2);
        cfg(25, 5, 5);
        req(0, 0);
        cfg(10, 0, 0);
        req(10, 0);
        req(10, 0);
        req(10, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 8) == 0,
                  $urandom_range(0, 31),
                  (($urandom % 4) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63),
                  $urandom_range(0, 63),
                  ($urandom % 16) == 0,
                  ($urandom % 4) != 0,
                  $urandom_range(0, 27),
                  $urandom_range(0, 3));
        end

        // Reset asserted while an output is valid
        cfg(1, 20, 7);
        drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
        req(1, 3);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_addr",  {21'd0, out_addr},  32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        exp_q.delete();
        model_reset();
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;
        req(1, 3);
        req(1, 3);
        req(3, 1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin_phase_sequencer.md
Name: bin_phase_sequencer

Overview:
- Per-bin phase counter bank that generates sin/cos table addresses for a DFT octave stage.
- Parametrised successor to the fixed-period bin counters: per-bin period and start phase are runtime-programmable rather than hard-coded.
- Supports a variable per-request step, a registered address output for RAM-based trig tables, and a one-cycle bank-wide resync to the programmed start phases.
- Sits between the octave sample scheduler (request side) and the SinTables/CosTables lookup (output side).

Parameters:
- N, 6, counter width; max period 2**N samples.
- BINS, 24, number of bins, i.e. counters.
- STEP_W, 2, width of the per-request phase step.
- BW, $clog2(BINS), bin index width (derived, do not override).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  config write strobe
- cfg_bin  in  BW  config target bin
- cfg_max  in  N  period-1 (last valid phase) for cfg_bin
- cfg_start  in  N  start phase loaded on sync for cfg_bin
- sync  in  1  load every counter with its start phase
- req_valid  in  1  increment request
- req_ready  out  1  request accepted when req_valid & req_ready
- req_bin  in  BW  bin to read/advance
- req_step  in  STEP_W  phase advance amount
- out_valid  out  1  address valid
- out_addr  out  BW+N  {bin, phase} table address
- out_wrap  out  1  this advance wrapped the period
- out_err  out  1  illegal step, or counter found out of range

Behaviour:
- Storage: cnt[BINS], max_tab[BINS], start_tab[BINS], all flops, width N each.
- Reset (rst=0, async): cnt=0, max_tab=2**N-1, start_tab=0, out_valid=0, out_addr=0, out_wrap=0, out_err=0. req_ready is 0 while reset is asserted.
- req_ready = ~sync (combinational). No other stall source.
- Accept cycle (reads cnt[req_bin] as c, max_tab[req_bin] as m, step s):
  - If s > m: err=1, wrap=0, cnt unchanged.
  - Else if c > m (stale after a max reprogram): cnt←0, wrap=1, err=1.
  - Else: t = c + s, computed at N+1 bits. If t > m, cnt←t-m-1 and wrap=1; else cnt←t and wrap=0. err=0.
- Output registered, latency 1:
  - out_addr = {req_bin, c}, using the pre-advance phase.
  - out_wrap and out_err as computed above.
  - out_valid=1 the cycle after accept, else 0.
  - out_addr/out_wrap/out_err hold their last values when out_valid=0.
- Back-to-back requests to the same bin see the updated cnt; no bubble is required.
- Requests with req_bin ≥ BINS: not accepted into cnt; out_valid=1, out_err=1, out_addr={req_bin, 0}.
- cfg_we: max_tab and start_tab update at the clock edge; cnt is never written by cfg. A same-cycle accept to the same bin uses the OLD max_tab. cfg_bin ≥ BINS is ignored.
- sync:
  - All cnt←start_tab at the edge.
  - If cfg_we coincides, sync uses the OLD start_tab.
  - A request presented during sync is not accepted (req_ready=0), and out_valid=0 the next cycle.
- max_tab=0 (period 1): with step 0, cnt stays 0 and wrap=0. Any step ≥ 1 gives err.
- Reset asserted mid-stream: all state clears immediately, and any in-flight out_valid drops asynchronously.

Test Plan:
- Reset then 60 requests, bin 3, step 1, with max_tab[3] programmed to 50 → out_addr phase sequence 0..50,0..8. out_wrap=1 only on the request that read phase 50. out_valid each cycle after accept.
- Program bin 0 max=54, step 2; advance from cnt 53 → out phase 53, wrap=1, next phase 0 (53+2-54-1=0).
- Program start_tab[5]=23 and [23]=15, pulse sync together with req_valid → req_ready=0 that cycle and out_valid=0 next cycle. Then requests to bins 5 and 23 output phases 23 and 15.
- Advance bin 7 to 40, reprogram max_tab[7]=29, then request → out phase 40, out_err=1, out_wrap=1; next request outputs phase 0.
- cfg_we on bin 2 with max=9 in the same cycle as a step-3 request on bin 2 with cnt=8 under old max 63 → out phase 8, wrap=0, cnt=11. Next request outputs phase 11 with err=1 and wrap=1.
- Request with step=3 on bin whose max=2 → out_err=1, cnt unchanged. req_bin=24 (BINS=24) → out_err=1, no counter modified.
